inst_fetch: RTL and testbench

//  IF stage, directly upstream of mem_ctrl's IF port. Holds the PC, looks it up in a direct-mapped
//  one-word-per-line icache, and on a miss issues if_request/if_addr to mem_ctrl until the
//  if_enable pulse returns the instruction. Delivers (pc, inst) to the IF/ID latch. A jump from
//  EX redirects the PC and aborts any in-flight fetch.

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_fetch_if.sv | 16 +
 rtl/inst_fetch_icache.sv | 43 ++++
 rtl/inst_fetch.sv | 117 +++++++++++
 tb/tb_inst_fetch.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its icache.
package inst_fetch_pkg;

    localparam int ADDR_LEN          = 32;
    localparam int INST_LEN          = 32;
    localparam int ICACHE_INDEX_BITS = 6;
    localparam logic [INST_LEN-1:0] ZERO_WORD = '0;

    typedef enum logic {
        F_RUN  = 1'b0,
        F_MISS = 1'b1
    } fetch_state_t;

    // Sequential fetch advance; 32-bit modulo so 32'hFFFF_FFFC wraps to 0.
    function automatic logic [ADDR_LEN-1:0] next_pc(input logic [ADDR_LEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch port between the IF stage (master) and mem_ctrl (slave).
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    // if_request is a level held by IF until mem_ctrl answers with a one-cycle
    // if_enable pulse; if_inst is meaningful only while if_enable=1, and IF drops
    // if_request combinationally in that same cycle so no second fetch starts.
    logic [ADDR_LEN-1:0] if_addr;
    logic                if_request;
    logic [INST_LEN-1:0] if_inst;
    logic                if_enable;

    modport master (output if_addr, output if_request, input if_inst, input if_enable);
    modport slave  (input if_addr, input if_request, output if_inst, output if_enable);

endinterface

// File: rtl/inst_fetch_icache.sv
// Direct-mapped, one-word-per-line instruction cache: combinational lookup,
// one synchronous fill port, valid bits cleared asynchronously by rst.
module inst_fetch_icache
    import inst_fetch_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    localparam int TAG_BITS  = ADDR_LEN - INDEX_BITS - 2,
    localparam int LINES     = 1 << INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] idx,
    input  logic [TAG_BITS-1:0]   tag,
    output logic                  hit,
    output logic [INST_LEN-1:0]   data,
    input  logic                  wr_en,
    input  logic [INST_LEN-1:0]   wr_data
);

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [INST_LEN-1:0] data_mem [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only read through its valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= wr_data;
        end
    end

    assign hit  = valid[idx] && (tag_mem[idx] == tag);
    assign data = data_mem[idx];

endmodule

// File: rtl/inst_fetch.sv
// IF stage: holds the PC, looks it up in the icache, fetches misses from
// mem_ctrl and delivers (pc, inst) to the IF/ID latch. Jumps abort any fetch.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                  INDEX_BITS = ICACHE_INDEX_BITS,
    parameter logic [ADDR_LEN-1:0] RESET_PC   = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                stall,
    input  logic                jump_or_not,
    input  logic [ADDR_LEN-1:0] jump_addr,
    inst_fetch_if.master        mem,
    output logic [ADDR_LEN-1:0] id_pc,
    output logic [INST_LEN-1:0] id_inst,
    output logic                id_valid,
    output fetch_state_t        state_dbg
);

    localparam int TAG_BITS = ADDR_LEN - INDEX_BITS - 2;

    fetch_state_t        state_q, state_d;
    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic [ADDR_LEN-1:0] id_pc_d;
    logic [INST_LEN-1:0] id_inst_d;
    logic                id_valid_d;
    logic                req;
    logic                fill;
    logic                hit;
    logic [INST_LEN-1:0] line_data;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^pc_q[1:0];

    inst_fetch_icache #(.INDEX_BITS(INDEX_BITS)) u_icache (
        .clk     (clk),
        .rst     (rst),
        .idx     (pc_q[INDEX_BITS+1:2]),
        .tag     (pc_q[ADDR_LEN-1:INDEX_BITS+2]),
        .hit     (hit),
        .data    (line_data),
        .wr_en   (fill && rdy),
        .wr_data (mem.if_inst)
    );

    // Priority: jump > stall > hit/miss/fill. During F_MISS the PC is the
    // pending fetch address, so the fill index/tag come straight from pc_q.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc;
        id_inst_d  = id_inst;
        id_valid_d = id_valid;
        req        = 1'b0;
        fill       = 1'b0;
        if (jump_or_not) begin
            pc_d       = jump_addr;
            id_valid_d = 1'b0;
            state_d    = F_RUN;
        end else begin
            case (state_q)
                F_RUN: begin
                    if (!stall) begin
                        if (hit) begin
                            id_pc_d    = pc_q;
                            id_inst_d  = line_data;
                            id_valid_d = 1'b1;
                            pc_d       = next_pc(pc_q);
                        end else begin
                            req        = 1'b1;
                            id_valid_d = 1'b0;
                            state_d    = F_MISS;
                        end
                    end
                end
                F_MISS: begin
                    if (mem.if_enable) begin
                        fill    = 1'b1;
                        state_d = F_RUN;
                        if (!stall) begin
                            id_pc_d    = pc_q;
                            id_inst_d  = mem.if_inst;
                            id_valid_d = 1'b1;
                            pc_d       = next_pc(pc_q);
                        end
                    end else begin
                        req = 1'b1;
                    end
                end
                default: state_d = F_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= F_RUN;
            pc_q     <= RESET_PC;
            id_pc    <= '0;
            id_inst  <= ZERO_WORD;
            id_valid <= 1'b0;
        end else if (rdy) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            id_pc    <= id_pc_d;
            id_inst  <= id_inst_d;
            id_valid <= id_valid_d;
        end
    end

    assign mem.if_addr    = pc_q;
    assign mem.if_request = req && !rst;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios then random traffic,
// compared against a behavioural fetch/icache model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rdy = 1'b1;
    logic                stall = 1'b0;
    logic                jump_or_not = 1'b0;
    logic [ADDR_LEN-1:0] jump_addr = '0;
    logic [ADDR_LEN-1:0] id_pc;
    logic [INST_LEN-1:0] id_inst;
    logic                id_valid;
    fetch_state_t        state_dbg;

    inst_fetch_if mem_bus ();

    inst_fetch #(.INDEX_BITS(6), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .stall       (stall),
        .jump_or_not (jump_or_not),
        .jump_addr   (jump_addr),
        .mem         (mem_bus),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: program counter, "waiting on memory" flag, and a
    // direct-mapped cache holding the full address of the word in each line.
    logic [31:0] m_pc;
    bit          m_wait;
    bit          m_idv;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    bit          line_v [64];
    logic [31:0] line_a [64];
    logic [31:0] line_d [64];
    int          lat_left;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) & 32'd63);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 32'h0; m_wait = 0; m_idv = 0; m_id_pc = 0; m_id_inst = 0; lat_left = 0;
        for (int i = 0; i < 64; i++) line_v[i] = 0;
    endtask

    task automatic m_deliver(input logic [31:0] d);
        m_id_pc = m_pc; m_id_inst = d; m_idv = 1; m_pc = m_pc + 32'd4;
    endtask

    task automatic check_regs();
        check("id_valid", {31'b0, id_valid}, {31'b0, m_idv});
        check("state_is_miss", {31'b0, state_dbg == F_MISS}, {31'b0, m_wait});
        if (m_idv) begin
            check("id_pc", id_pc, m_id_pc);
            check("id_inst", id_inst, m_id_inst);
        end
    endtask

    // One clock cycle, entered and left at negedge. en_mode: 0 auto latency,
    // 1 force if_enable, 2 suppress if_enable.
    task automatic cycle(input bit r, input bit s, input bit j, input logic [31:0] ja,
                         input int en_mode);
        bit hit, en, exp_req;
        int ix;
        ix = line_of(m_pc);
        rdy = r; stall = s; jump_or_not = j; jump_addr = ja;
        hit = !m_wait && line_v[ix] && (line_a[ix] == m_pc);
        case (en_mode)
            1:       en = 1;
            2:       en = 0;
            default: en = m_wait && r && (lat_left == 0);
        endcase
        mem_bus.if_enable = en;
        mem_bus.if_inst   = (en && !j) ? mem_word(m_pc) : 32'h0;
        exp_req = !j && (m_wait ? !en : (!s && !hit));
        #1;
        check("if_request", {31'b0, mem_bus.if_request}, {31'b0, exp_req});
        if (exp_req) check("if_addr", mem_bus.if_addr, m_pc);
        @(posedge clk);
        if (r) begin
            if (j) begin
                m_pc = ja; m_idv = 0; m_wait = 0;
            end else if (!m_wait) begin
                if (!s) begin
                    if (hit) m_deliver(line_d[ix]);
                    else begin
                        m_idv = 0; m_wait = 1; lat_left = int'($urandom_range(0, 3));
                    end
                end
            end else if (en) begin
                line_v[ix] = 1; line_a[ix] = m_pc; line_d[ix] = mem_word(m_pc);
                m_wait = 0;
                if (!s) m_deliver(mem_word(m_pc));
            end else if (lat_left > 0) begin
                lat_left--;
            end
        end
        #1;
        check_regs();
        @(negedge clk);
        mem_bus.if_enable = 0;
        mem_bus.if_inst   = 32'h0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 32'h0, 0);
    endtask

    task automatic jump_to(input logic [31:0] a);
        cycle(1, 0, 1, a, 2);
    endtask

    initial begin
        mem_bus.if_enable = 0;
        mem_bus.if_inst   = 32'h0;
        m_reset();

        // Reset: outputs cleared, no request even though pc=0 would miss.
        repeat (2) @(negedge clk);
        check("rst_if_request", {31'b0, mem_bus.if_request}, 32'h0);
        check("rst_id_valid", {31'b0, id_valid}, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_inst", id_inst, 32'h0);
        rst = 0;

        // 1: cold start, miss held for two cycles then filled.
        cycle(1, 0, 0, 0, 2);
        cycle(1, 0, 0, 0, 2);
        cycle(1, 0, 0, 0, 2);
        cycle(1, 0, 0, 0, 1);
        check("cold_inst", id_inst, 32'h0000_0013);

        // 2: fill 0x4, 0x8, then jump back: three hits in three cycles.
        while (m_pc != 32'hC) run(1);
        jump_to(32'h0);
        run(3);
        check("loop_pc_after_hits", id_pc, 32'h8);

        // 3: jump coinciding with completion of a fetch to 0x10.
        jump_to(32'h10);
        cycle(1, 0, 0, 0, 2);
        cycle(1, 0, 0, 0, 2);
        cycle(1, 0, 1, 32'h100, 1);
        run(4);
        jump_to(32'h10);
        run(3);

        // 4: completion under stall fills without delivery; release then hits.
        jump_to(32'h200);
        cycle(1, 0, 0, 0, 2);
        cycle(1, 1, 0, 0, 1);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("stall_fill_hit_pc", id_pc, 32'h200);

        // 5: aliasing lines 0x0 / 0x100 evict each other.
        jump_to(32'h0);   run(5);
        jump_to(32'h100); run(5);
        jump_to(32'h0);   run(5);

        // rdy=0 freezes everything, including a pending miss.
        jump_to(32'h300);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
        run(6);

        // PC wraps from the top of the address space.
        jump_to(32'hFFFF_FFFC);
        run(6);

        // 6: reset in the middle of a miss.
        jump_to(32'h340);
        cycle(1, 0, 0, 0, 2);
        rst = 1;
        #1;
        check("midrst_if_request", {31'b0, mem_bus.if_request}, 32'h0);
        check("midrst_id_valid", {31'b0, id_valid}, 32'h0);
        check("midrst_state_run", {31'b0, state_dbg == F_MISS}, 32'h0);
        m_reset();
        @(negedge clk);
        rst = 0;
        run(4);

        // Random traffic with aliasing addresses, stalls, jumps and rdy gaps.
        for (int i = 0; i < 400; i++) begin
            bit r, s, j;
            logic [31:0] ja;
            r  = ($urandom_range(0, 9) != 0);
            s  = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 11) == 0);
            ja = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            cycle(r, s, j, ja, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
